// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - Wishbone cycle-type / burst-type encodings and burst FSM state type
package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } burst_state_t;

  function automatic logic cti_is_burst(input logic [2:0] cti);
    return (cti == CTI_CONST) || (cti == CTI_INCR);
  endfunction

endpackage

// File: rtl/wb_burst_adr_gen.sv
// rtl/wb_burst_adr_gen.sv - next word address for registered-feedback burst slaves
// WB_RAM_BURST_WRAP_EN enables bte wrap-4/8/16; otherwise incrementing bursts are linear.
module wb_burst_adr_gen
  import wb_pkg::*;
#(
  parameter int WORD_WIDTH = 14
) (
  input  logic [WORD_WIDTH-1:0] adr,
  input  logic [2:0]            cti,
  input  logic [1:0]            bte,
  output logic [WORD_WIDTH-1:0] next_adr
);

  logic [WORD_WIDTH-1:0] incr;
  logic [WORD_WIDTH-1:0] wrap_mask;

  assign incr = adr + WORD_WIDTH'(1);

`ifdef WB_RAM_BURST_WRAP_EN
  // Bits under the mask take the incremented value; bits above stay fixed to the aligned block.
  always_comb begin
    wrap_mask = '1;
    case (bte)
      BTE_WRAP4:  wrap_mask = WORD_WIDTH'(3);
      BTE_WRAP8:  wrap_mask = WORD_WIDTH'(7);
      BTE_WRAP16: wrap_mask = WORD_WIDTH'(15);
      default:    wrap_mask = '1;
    endcase
  end
`else
  logic unused_bte;
  assign unused_bte = ^bte;
  assign wrap_mask  = '1;
`endif

  always_comb begin
    next_adr = adr;
    if (cti == CTI_INCR) begin
      next_adr = (adr & ~wrap_mask) | (incr & wrap_mask);
    end
  end

endmodule

// File: rtl/wb_ram_burst.sv
// rtl/wb_ram_burst.sv - Wishbone registered-feedback burst RAM slave, one beat per clock in bursts
// WB_RAM_BURST_WRAP_EN (in wb_burst_adr_gen) enables wrap bursts.
module wb_ram_burst
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int SELECT_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   adr_i,
  input  logic [DATA_WIDTH-1:0]   dat_i,
  output logic [DATA_WIDTH-1:0]   dat_o,
  input  logic                    we_i,
  input  logic [SELECT_WIDTH-1:0] sel_i,
  input  logic                    stb_i,
  input  logic                    cyc_i,
  input  logic [2:0]              cti_i,
  input  logic [1:0]              bte_i,
  output logic                    ack_o
);

  localparam int LANE_WIDTH = DATA_WIDTH / SELECT_WIDTH;
  localparam int LANE_BITS  = $clog2(SELECT_WIDTH);
  localparam int WORD_WIDTH = ADDR_WIDTH - LANE_BITS;
  localparam int DEPTH      = 2 ** WORD_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  logic [WORD_WIDTH-1:0] word_adr;
  logic [WORD_WIDTH-1:0] next_adr;
  logic [WORD_WIDTH-1:0] rd_adr;
  logic [DATA_WIDTH-1:0] rd_data;
  burst_state_t          state;
  burst_state_t          state_d;
  logic                  req;
  logic                  wr_en;
  logic                  ack_d;
  logic                  load;
  logic                  use_next;
  logic                  unused_adr;

  assign word_adr   = adr_i[ADDR_WIDTH-1:LANE_BITS];
  assign unused_adr = ^adr_i;
  assign req        = cyc_i & stb_i;
  assign wr_en      = req & we_i & ack_o;

  wb_burst_adr_gen #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_adr_gen (
    .adr     (word_adr),
    .cti     (cti_i),
    .bte     (bte_i),
    .next_adr(next_adr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // In IDLE an ack'd beat is followed by a dead cycle; in BURST the ack stays up while the master continues.
  always_comb begin
    state_d  = state;
    ack_d    = 1'b0;
    load     = 1'b0;
    use_next = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req && !ack_o) begin
          ack_d = 1'b1;
          load  = 1'b1;
          if (cti_is_burst(cti_i)) begin
            state_d = ST_BURST;
          end
        end
      end
      ST_BURST: begin
        if (ack_o && req && cti_is_burst(cti_i)) begin
          ack_d    = 1'b1;
          load     = 1'b1;
          use_next = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rd_adr = use_next ? next_adr : word_adr;

  // Forward the write committing on this edge so the next beat sees it.
  always_comb begin
    rd_data = mem[rd_adr];
    if (wr_en && (rd_adr == word_adr)) begin
      for (int n = 0; n < SELECT_WIDTH; n++) begin
        if (sel_i[n]) begin
          rd_data[n*LANE_WIDTH +: LANE_WIDTH] = dat_i[n*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_o <= 1'b0;
      dat_o <= '0;
    end else begin
      ack_o <= ack_d;
      if (load) begin
        dat_o <= rd_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      for (int n = 0; n < SELECT_WIDTH; n++) begin
        if (sel_i[n]) begin
          mem[word_adr][n*LANE_WIDTH +: LANE_WIDTH] <= dat_i[n*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_ram_burst.sv
// tb/tb_wb_ram_burst.sv - directed bench for wb_ram_burst with a beat-data scoreboard
module tb_wb_ram_burst;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] adr_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        we_i;
  logic [3:0]  sel_i;
  logic        stb_i;
  logic        cyc_i;
  logic [2:0]  cti_i;
  logic [1:0]  bte_i;
  logic        ack_o;

  int          checks = 0;
  int          errors = 0;
  int          waits;
  logic [31:0] exp_q[$];
  string       name_q[$];

  always #5 clk = ~clk;

  wb_ram_burst #(
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (16),
    .SELECT_WIDTH(4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .adr_i(adr_i),
    .dat_i(dat_i),
    .dat_o(dat_o),
    .we_i (we_i),
    .sel_i(sel_i),
    .stb_i(stb_i),
    .cyc_i(cyc_i),
    .cti_i(cti_i),
    .bte_i(bte_i),
    .ack_o(ack_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_beat(input string name, input logic [31:0] d);
    exp_q.push_back(d);
    name_q.push_back(name);
  endtask

  // Scoreboard: every accepted beat (ack with cyc&stb) must match the next queued value.
  always @(negedge clk) begin
    if (!rst && ack_o && cyc_i && stb_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: dat_o %h with no expected entry", dat_o);
      end else begin
        check(name_q.pop_front(), dat_o, exp_q.pop_front());
      end
    end
  end

  task automatic idle();
    cyc_i = 1'b0;
    stb_i = 1'b0;
    we_i  = 1'b0;
    cti_i = CTI_CLASSIC;
    bte_i = BTE_LINEAR;
    sel_i = 4'b0000;
  endtask

  task automatic beat(input logic w, input logic [15:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [2:0] c, input logic [1:0] b);
    cyc_i = 1'b1;
    stb_i = 1'b1;
    we_i  = w;
    adr_i = a;
    dat_i = d;
    sel_i = s;
    cti_i = c;
    bte_i = b;
    waits = 0;
    @(negedge clk);
    while (!ack_o && waits < 8) begin
      waits++;
      @(negedge clk);
    end
    if (!ack_o) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: no ack at adr %h after %0d cycles", a, waits);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic gap_check(input string name);
    idle();
    @(negedge clk);
    check(name, 32'(ack_o), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cw[4];
    rst   = 1'b1;
    adr_i = '0;
    dat_i = '0;
    idle();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_ack", 32'(ack_o), 32'd0);
    check("reset_dat", dat_o, 32'd0);
    @(posedge clk);
    #1;

    // classic write of two lanes, then classic read
    expect_beat("a_wr_dat", 32'h0000_0000);
    beat(1'b1, 16'h0010, 32'hDEAD_BEEF, 4'b0011, CTI_CLASSIC, BTE_LINEAR);
    check("a_wr_wait", waits, 1);
    gap_check("a_wr_ack_one_cycle");
    expect_beat("a_rd_dat", 32'h0000_BEEF);
    beat(1'b0, 16'h0010, 32'h0, 4'b1111, CTI_CLASSIC, BTE_LINEAR);
    check("a_rd_wait", waits, 1);
    gap_check("a_rd_ack_one_cycle");

    expect_beat("top_wr_dat", 32'h0000_0000);
    beat(1'b1, 16'hFFFC, 32'h7777_1234, 4'b1111, CTI_CLASSIC, BTE_LINEAR);
    gap_check("top_wr_end");

    // fill words 0..5; beat 4 shows the old partial-lane content of word 4
    for (int k = 0; k < 6; k++) begin
      expect_beat("fill_dat", (k == 4) ? 32'h0000_BEEF : 32'h0);
      beat(1'b1, 16'(k * 4), 32'hC0DE_0000 | 32'(k), 4'b1111,
           (k == 5) ? CTI_EOB : CTI_INCR, BTE_LINEAR);
    end
    gap_check("fill_end");

    for (int k = 0; k < 4; k++) begin
      expect_beat("b_dat", 32'hC0DE_0000 | 32'(k));
      beat(1'b0, 16'(k * 4), 32'h0, 4'b1111, (k == 3) ? CTI_EOB : CTI_INCR, BTE_LINEAR);
      check("b_wait", waits, (k == 0) ? 1 : 0);
    end
    gap_check("b_ack_low_after");

`ifdef WB_RAM_BURST_WRAP_EN
    cw = '{2, 3, 0, 1};
`else
    cw = '{2, 3, 4, 5};
`endif
    for (int k = 0; k < 4; k++) begin
      expect_beat("c_wrap4_dat", 32'hC0DE_0000 | 32'(cw[k]));
      beat(1'b0, 16'(cw[k] * 4), 32'h0, 4'b1111, (k == 3) ? CTI_EOB : CTI_INCR, BTE_WRAP4);
    end
    gap_check("c_end");

    expect_beat("d_top_dat", 32'h7777_1234);
    beat(1'b0, 16'hFFFC, 32'h0, 4'b1111, CTI_INCR, BTE_LINEAR);
    expect_beat("d_wrap_word0_dat", 32'hC0DE_0000);
    beat(1'b0, 16'h0000, 32'h0, 4'b1111, CTI_EOB, BTE_LINEAR);
    check("d_wait", waits, 0);
    gap_check("d_end");

    // strobe dropped after beat 2, then restarted at beat 3
    expect_beat("e_dat0", 32'hC0DE_0000);
    beat(1'b0, 16'h0000, 32'h0, 4'b1111, CTI_INCR, BTE_LINEAR);
    expect_beat("e_dat1", 32'hC0DE_0001);
    beat(1'b0, 16'h0004, 32'h0, 4'b1111, CTI_INCR, BTE_LINEAR);
    stb_i = 1'b0;
    @(negedge clk);
    check("e_ack_held", 32'(ack_o), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("e_ack_drop", 32'(ack_o), 32'd0);
    check("e_dat_not_reloaded", dat_o, 32'hC0DE_0002);
    @(posedge clk);
    #1;
    expect_beat("e_dat2", 32'hC0DE_0002);
    beat(1'b0, 16'h0008, 32'h0, 4'b1111, CTI_INCR, BTE_LINEAR);
    check("e_restart_wait", waits, 1);
    expect_beat("e_dat3", 32'hC0DE_0003);
    beat(1'b0, 16'h000C, 32'h0, 4'b1111, CTI_EOB, BTE_LINEAR);
    gap_check("e_end");

    // constant-address burst: write then lane-wise bypassed read-back
    expect_beat("g_dat0", 32'h0000_0000);
    beat(1'b1, 16'h0018, 32'hAAAA_5555, 4'b1111, CTI_CONST, BTE_LINEAR);
    expect_beat("g_bypass_full", 32'hAAAA_5555);
    beat(1'b1, 16'h0018, 32'h1234_5678, 4'b0100, CTI_CONST, BTE_LINEAR);
    expect_beat("g_bypass_lane", 32'hAA34_5555);
    beat(1'b0, 16'h0018, 32'h0, 4'b1111, CTI_EOB, BTE_LINEAR);
    gap_check("g_end");

    // reset in the middle of a write burst
    expect_beat("f_dat0", 32'hC0DE_0002);
    beat(1'b1, 16'h0008, 32'h1111_1111, 4'b1111, CTI_INCR, BTE_LINEAR);
    expect_beat("f_dat1", 32'hC0DE_0003);
    beat(1'b1, 16'h000C, 32'h2222_2222, 4'b1111, CTI_INCR, BTE_LINEAR);
    adr_i = 16'h0010;
    dat_i = 32'h3333_3333;
    cti_i = CTI_EOB;
    rst   = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    @(negedge clk);
    check("f_rst_ack", 32'(ack_o), 32'd0);
    check("f_rst_dat", dat_o, 32'd0);
    @(posedge clk);
    #1;
    expect_beat("f_keep0", 32'h1111_1111);
    beat(1'b0, 16'h0008, 32'h0, 4'b1111, CTI_INCR, BTE_LINEAR);
    check("f_restart_wait", waits, 1);
    expect_beat("f_keep1", 32'h2222_2222);
    beat(1'b0, 16'h000C, 32'h0, 4'b1111, CTI_INCR, BTE_LINEAR);
    expect_beat("f_not_written", 32'hC0DE_0004);
    beat(1'b0, 16'h0010, 32'h0, 4'b1111, CTI_EOB, BTE_LINEAR);
    gap_check("f_end");

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
